uart_rx_buffer: RTL and testbench
=================================

// Module: uart_rx_buffer
// PURPOSE
//  Receive-side byte buffer downstream of the UART receiver. Captures each byte the
//  receiver flags, stores it in a DEPTH-entry FIFO and presents it to the core's
//  memory-mapped UART read path as a show-ahead queue. Also reports status
//  (empty/full/count) and raises a sticky overrun flag for dropped bytes.
// PARAMETERS
//  DEPTH   8  FIFO entries; power of two, >= 2
//  DATA_W  8  byte width; matches receiver data_out
// PORTS
//  clk          in   1               system clock; all state on rising edge
//  rst          in   1               asynchronous, active-high reset
//  rx_data      in   DATA_W          receiver data_out; stable while rx_flag high
//  rx_flag      in   1               receiver recive_flag level (baud-clock domain)
//  rd_en        in   1               pop head entry (ignored when empty)
//  clr_overrun  in   1               clear sticky overrun
//  rd_data      out  DATA_W          head entry, combinational from mem[rd_ptr]
//  empty        out  1               count == 0
//  full         out  1               count == DEPTH
//  count        out  $clog2(DEPTH+1) entries held
//  overrun      out  1               sticky: a byte was dropped on full
//  irq          out  1               interrupt request to core
// BEHAVIOUR
//  - Reset: rd_ptr=wr_ptr=count=0, overrun=0, sync flops=0, FSM=ARMED; so empty=1,
//    full=0, irq=0. rd_data undefined while empty (bench must not check it).
//  - rx_flag passes through a 2-flop synchronizer (s2 = synchronized level).
//  - Capture FSM: ARMED: s2==1 -> assert push for one cycle, go HELD.
//    HELD: s2==0 -> ARMED. Exactly one push per rx_flag high pulse of any length.
//  - Latency: push occurs on the 3rd clk edge after rx_flag rises; count/empty
//    update on that edge. rx_data sampled directly on the push edge.
//  - Push when not full: mem[wr_ptr]<=rx_data, wr_ptr++ (wraps DEPTH-1 -> 0).
//  - Pop (rd_en & !empty): rd_ptr++ (wraps); rd_data shows next entry after edge.
//  - Simultaneous push and pop: not empty -> both done, count unchanged (incl. full);
//    empty -> push only, pop ignored, count 0 -> 1.
//  - Push when full with no pop: byte dropped, memory/pointers unchanged, overrun<=1.
//  - overrun: set on drop; clr_overrun clears; drop and clear same cycle -> stays 1.
//  - irq = !empty (or threshold/overrun form below).
//  - rst mid-operation: all contents discarded immediately (async); FSM ARMED, so a
//    rx_flag still high after reset release produces one push once synchronized.
// CONFIGURATION
//  UART_RX_BUF_THRESH_IRQ_EN defined: extra input rx_thresh [$clog2(DEPTH+1)] and
//    irq = (count >= rx_thresh && rx_thresh != 0) | overrun; rx_thresh == 0 -> irq = overrun.
//  Not defined: no rx_thresh port; irq = !empty.
// TESTING
//  - Reset then single rx_flag pulse, rx_data=8'hA5 -> push on 3rd edge: count=1,
//    empty=0, rd_data=8'hA5, irq=1; rd_en one cycle -> empty=1, count=0.
//  - rx_flag held high 50 cycles, rx_data=8'h3C -> exactly one entry (count=1).
//  - Push 8'h01..8'h08 (DEPTH=8) -> full=1; push 8'h09 -> overrun=1, count=8;
//    read all 8 -> 8'h01..8'h08 in order, overrun still 1; clr_overrun -> 0.
//  - Full FIFO, rd_en on push edge with 8'h77 -> count stays 8, head advances,
//    overrun=0; drain -> 8'h77 last. Repeat 20 bytes through to check pointer wrap.
//  - Empty FIFO, rd_en held high through a push of 8'h5A -> count=1 after push edge,
//    then 0 next edge; rd_data was 8'h5A; no underflow (count never wraps).
//  - THRESH_IRQ_EN, rx_thresh=3: pushes 1,2 -> irq=0; push 3 -> irq=1; pop -> irq=0;
//    assert rst with 5 entries mid-run -> count=0, overrun=0, irq=0 immediately.

Source files
------------

// File: rtl/uart_rx_buffer.sv
// rtl/uart_rx_buffer.sv - receive byte FIFO with synchronized capture, overrun and irq
// Optional threshold interrupt enabled by defining UART_RX_BUF_THRESH_IRQ_EN.
module uart_rx_buffer #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_flag,
    input  logic              rd_en,
    input  logic              clr_overrun,
`ifdef UART_RX_BUF_THRESH_IRQ_EN
    input  logic [CW-1:0]     rx_thresh,
`endif
    output logic [DATA_W-1:0] rd_data,
    output logic              empty,
    output logic              full,
    output logic [CW-1:0]     count,
    output logic              overrun,
    output logic              irq
);

    typedef enum logic {
        ST_ARMED = 1'b0,
        ST_HELD  = 1'b1
    } cap_state_t;

    cap_state_t        r_state;
    cap_state_t        w_state_nxt;
    logic              r_sync1;
    logic              r_sync2;
    logic              w_push;
    logic              w_pop;
    logic              w_wr;
    logic              w_drop;
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              r_overrun;
    logic [DATA_W-1:0] r_mem [DEPTH];

    // rx_flag comes from the baud-clock domain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= rx_flag;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_ARMED;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        case (r_state)
            ST_ARMED: begin
                if (r_sync2) begin
                    w_push      = 1'b1;
                    w_state_nxt = ST_HELD;
                end
            end
            ST_HELD: begin
                if (!r_sync2) begin
                    w_state_nxt = ST_ARMED;
                end
            end
            default: w_state_nxt = ST_ARMED;
        endcase
    end

    // A pop on the same edge frees the slot the push writes into, even when full
    assign w_pop  = rd_en && (r_count != '0);
    assign w_wr   = w_push && (!full || w_pop);
    assign w_drop = w_push && full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= rx_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Drop wins over a same-cycle clear so the loss is never hidden
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (clr_overrun) begin
            r_overrun <= 1'b0;
        end
    end

    assign rd_data = r_mem[r_rd_ptr];
    assign count   = r_count;
    assign empty   = (r_count == '0);
    assign full    = (r_count == CW'(DEPTH));
    assign overrun = r_overrun;

`ifdef UART_RX_BUF_THRESH_IRQ_EN
    assign irq = ((rx_thresh != '0) && (r_count >= rx_thresh)) || r_overrun;
`else
    assign irq = !empty;
`endif

endmodule

// File: tb/tb_uart_rx_buffer.sv
// tb/tb_uart_rx_buffer.sv - directed self-checking bench for uart_rx_buffer
module tb_uart_rx_buffer;

    localparam int DEPTH  = 8;
    localparam int DATA_W = 8;
    localparam int CW     = $clog2(DEPTH + 1);

    logic              clk;
    logic              rst;
    logic [DATA_W-1:0] rx_data;
    logic              rx_flag;
    logic              rd_en;
    logic              clr_overrun;
    logic [CW-1:0]     rx_thresh;
    logic [DATA_W-1:0] rd_data;
    logic              empty;
    logic              full;
    logic [CW-1:0]     count;
    logic              overrun;
    logic              irq;

    int checks;
    int errors;

    uart_rx_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_flag     (rx_flag),
        .rd_en       (rd_en),
        .clr_overrun (clr_overrun),
`ifdef UART_RX_BUF_THRESH_IRQ_EN
        .rx_thresh   (rx_thresh),
`endif
        .rd_data     (rd_data),
        .empty       (empty),
        .full        (full),
        .count       (count),
        .overrun     (overrun),
        .irq         (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       flag;
        logic [7:0] data;
        logic       rd;
        int         e_count;
        logic       e_ovr;
        logic       chk_data;
        logic [7:0] e_data;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic f_irq(input int cnt, input logic ovr);
`ifdef UART_RX_BUF_THRESH_IRQ_EN
        return ((rx_thresh != 0) && (cnt >= int'(rx_thresh))) || ovr;
`else
        return (cnt != 0) || (ovr && 1'b0);
`endif
    endfunction

    task automatic chk_status(input string tag, input int e_cnt, input logic e_ovr);
        chk({tag, ".count"}, 32'(count), 32'(e_cnt));
        chk({tag, ".empty"}, 32'(empty), 32'(e_cnt == 0));
        chk({tag, ".full"}, 32'(full), 32'(e_cnt == DEPTH));
        chk({tag, ".overrun"}, 32'(overrun), 32'(e_ovr));
        chk({tag, ".irq"}, 32'(irq), 32'(f_irq(e_cnt, e_ovr)));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse rx_flag for one cycle; push lands on the 3rd edge, one more edge re-arms
    task automatic push_byte(input logic [7:0] d);
        rx_data = d;
        rx_flag = 1'b1;
        tick();
        rx_flag = 1'b0;
        tick();
        tick();
        tick();
    endtask

    task automatic pop_byte();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        rx_data     = '0;
        rx_flag     = 1'b0;
        rd_en       = 1'b0;
        clr_overrun = 1'b0;
        rx_thresh   = CW'(1);

        vecs.push_back('{1'b1, 8'hA5, 1'b0, 0, 1'b0, 1'b0, 8'h00});
        vecs.push_back('{1'b0, 8'hA5, 1'b0, 0, 1'b0, 1'b0, 8'h00});
        vecs.push_back('{1'b0, 8'hA5, 1'b0, 1, 1'b0, 1'b1, 8'hA5});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b0, 8'h00});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b0, 8'h00});

        tick();
        tick();
        chk_status("reset", 0, 1'b0);
        rst = 1'b0;
        tick();
        chk_status("post_reset", 0, 1'b0);

        foreach (vecs[i]) begin
            rx_flag = vecs[i].flag;
            rx_data = vecs[i].data;
            rd_en   = vecs[i].rd;
            tick();
            chk_status($sformatf("vec%0d", i), vecs[i].e_count, vecs[i].e_ovr);
            if (vecs[i].chk_data) begin
                chk($sformatf("vec%0d.rd_data", i), 32'(rd_data), 32'(vecs[i].e_data));
            end
        end
        rd_en = 1'b0;
        tick();

        // Long rx_flag level yields one entry
        rx_data = 8'h3C;
        rx_flag = 1'b1;
        repeat (50) tick();
        chk_status("hold50", 1, 1'b0);
        rx_flag = 1'b0;
        repeat (4) tick();
        chk_status("hold_release", 1, 1'b0);
        chk("hold.rd_data", 32'(rd_data), 32'h3C);
        pop_byte();
        chk_status("hold_pop", 0, 1'b0);

        // Fill, overflow, drain in order
        for (int i = 1; i <= 8; i++) push_byte(8'(i));
        chk_status("fill8", 8, 1'b0);
        push_byte(8'h09);
        chk_status("overflow", 8, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("drain%0d.rd_data", i), 32'(rd_data), 32'(i));
            pop_byte();
        end
        chk_status("drained", 0, 1'b1);
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        chk_status("clr_overrun", 0, 1'b0);

        // Full FIFO with pop on the push edge
        for (int i = 0; i < 8; i++) push_byte(8'h11 + 8'(i));
        chk_status("refill", 8, 1'b0);
        rx_data = 8'h77;
        rx_flag = 1'b1;
        tick();
        rx_flag = 1'b0;
        tick();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk_status("full_pushpop", 8, 1'b0);
        chk("full_pushpop.rd_data", 32'(rd_data), 32'h12);
        tick();
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain_pp%0d.rd_data", i), 32'(rd_data),
                (i < 7) ? 32'(8'h12 + 8'(i)) : 32'h77);
            pop_byte();
        end
        chk_status("drain_pp_done", 0, 1'b0);

        // Stream 20 bytes to wrap both pointers
        for (int i = 0; i < 20; i++) begin
            push_byte(8'h80 + 8'(i));
            chk($sformatf("wrap%0d.rd_data", i), 32'(rd_data), 32'(8'h80 + 8'(i)));
            pop_byte();
        end
        chk_status("wrap_done", 0, 1'b0);

        // rd_en held on an empty FIFO while a byte arrives
        rd_en   = 1'b1;
        rx_data = 8'h5A;
        rx_flag = 1'b1;
        tick();
        rx_flag = 1'b0;
        tick();
        chk_status("empty_rd_pre", 0, 1'b0);
        tick();
        chk_status("empty_rd_push", 1, 1'b0);
        chk("empty_rd.rd_data", 32'(rd_data), 32'h5A);
        tick();
        chk_status("empty_rd_pop", 0, 1'b0);
        repeat (3) tick();
        chk_status("empty_rd_nounderflow", 0, 1'b0);
        rd_en = 1'b0;

        // Async reset mid-run with rx_flag still high afterwards
        for (int i = 0; i < 5; i++) push_byte(8'hC0 + 8'(i));
        chk_status("pre_rst", 5, 1'b0);
        rx_data = 8'hE1;
        rx_flag = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk_status("async_rst", 0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        tick();
        chk_status("rst_rel_wait", 0, 1'b0);
        tick();
        chk_status("rst_rel_push", 1, 1'b0);
        chk("rst_rel.rd_data", 32'(rd_data), 32'hE1);
        repeat (5) tick();
        chk_status("rst_rel_once", 1, 1'b0);
        rx_flag = 1'b0;
        repeat (2) tick();

`ifdef UART_RX_BUF_THRESH_IRQ_EN
        do_reset();
        rx_thresh = CW'(3);
        push_byte(8'h01);
        chk("th.push1.irq", 32'(irq), 32'h0);
        push_byte(8'h02);
        chk("th.push2.irq", 32'(irq), 32'h0);
        push_byte(8'h03);
        chk("th.push3.irq", 32'(irq), 32'h1);
        pop_byte();
        chk("th.pop.irq", 32'(irq), 32'h0);
        for (int i = 0; i < 3; i++) push_byte(8'h10 + 8'(i));
        chk_status("th.five", 5, 1'b0);
        rx_thresh = '0;
        #1;
        chk("th.zero.irq", 32'(irq), 32'h0);
        rx_thresh = CW'(3);
        #2 rst = 1'b1;
        #1;
        chk_status("th.rst", 0, 1'b0);
        chk("th.rst.irq", 32'(irq), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        tick();
`else
        do_reset();
        chk_status("final_reset", 0, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
